// File: rtl/activation_pkg.sv
// Shared constants and elaboration-time sigmoid helpers for the activation unit.
// The real-valued math here only ever builds the lookup table contents.
package activation_pkg;

  localparam int unsigned DefArgWidth = 16;
  localparam int unsigned DefArgFrac  = 8;
  localparam int unsigned DefActWidth = 8;
  localparam int unsigned DefLutBits  = 12;
  localparam int unsigned DefLimit    = 6;
  localparam int unsigned DefDepth    = 4;

  // exp(y) by Taylor series on y/64, then six squarings to undo the scaling.
  function automatic real exp_real(input real y);
    real r;
    real term;
    real sum;
    r    = y / 64.0;
    term = 1.0;
    sum  = 1.0;
    for (int k = 1; k <= 12; k++) begin
      term = term * r / real'(k);
      sum  = sum + term;
    end
    for (int k = 0; k < 6; k++) begin
      sum = sum * sum;
    end
    return sum;
  endfunction

  function automatic real sigmoid(input real x);
    return 1.0 / (1.0 + exp_real(-x));
  endfunction

  // Table word for address idx; the address is the two's-complement low bits of the argument.
  function automatic int unsigned lut_entry(input int unsigned idx, input int unsigned lut_bits,
                                            input int unsigned arg_frac,
                                            input int unsigned act_width);
    int          x;
    int unsigned v;
    int unsigned top;
    x   = (idx >= (32'd1 << (lut_bits - 1))) ? int'(idx) - int'(32'd1 << lut_bits) : int'(idx);
    v   = $rtoi(real'(32'd1 << act_width) * sigmoid(real'(x) / real'(32'd1 << arg_frac)));
    top = (32'd1 << act_width) - 1;
    return (v > top) ? top : v;
  endfunction

endpackage

// File: rtl/activation_if.sv
// Stream bundle of the activation unit: argument in, activation out, feedback in, delta out.
// slave is the unit's view, master the view of whoever drives arguments and feedback.
interface activation_if import activation_pkg::*; #(
  parameter int unsigned ARG_WIDTH = DefArgWidth,
  parameter int unsigned ACT_WIDTH = DefActWidth
);
  logic                 argument_valid;
  logic [ARG_WIDTH-1:0] argument_data;
  logic                 argument_ready;
  logic                 activation_valid;
  logic [ACT_WIDTH-1:0] activation_data;
  logic                 activation_ready;
  logic                 feedback_valid;
  logic [ARG_WIDTH-1:0] feedback_data;
  logic                 feedback_ready;
  logic                 delta_valid;
  logic [ARG_WIDTH-1:0] delta_data;
  logic                 delta_ready;

  modport slave (
    input  argument_valid, argument_data, activation_ready, feedback_valid, feedback_data,
           delta_ready,
    output argument_ready, activation_valid, activation_data, feedback_ready, delta_valid,
           delta_data
  );

  modport master (
    output argument_valid, argument_data, activation_ready, feedback_valid, feedback_data,
           delta_ready,
    input  argument_ready, activation_valid, activation_data, feedback_ready, delta_valid,
           delta_data
  );
endinterface

// File: rtl/activation_fifo.sv
// In-order store of forward results awaiting their feedback; head is the oldest entry.
// The caller never pushes when full nor pops when empty.
module activation_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ACT_WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [ACT_WIDTH-1:0]         push_data,
  input  logic                         pop,
  output logic [ACT_WIDTH-1:0]         head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ACT_WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/activation_unit.sv
// Sigmoid forward path via lookup table plus a backward path scaling feedback by y*(1-y).
// Define ACTIVATION_UNIT_ROUND_EN to round the delta half up instead of flooring it.
module activation_unit import activation_pkg::*; #(
  parameter int unsigned ARG_WIDTH = DefArgWidth,
  parameter int unsigned ARG_FRAC  = DefArgFrac,
  parameter int unsigned ACT_WIDTH = DefActWidth,
  parameter int unsigned LUT_BITS  = DefLutBits,
  parameter int unsigned LIMIT     = DefLimit,
  parameter int unsigned DEPTH     = DefDepth
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       train,
  activation_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0] pending
);
  localparam int unsigned LutSize = 32'd1 << LUT_BITS;
  localparam int unsigned CntW    = $clog2(DEPTH + 1);
  localparam int unsigned ProdW   = ARG_WIDTH + ACT_WIDTH + 2;
  localparam int unsigned YW      = 2 * ACT_WIDTH + 1;
  localparam logic signed [ARG_WIDTH-1:0] ArgHi = ARG_WIDTH'(LIMIT << ARG_FRAC);
  localparam logic signed [ARG_WIDTH-1:0] ArgLo = ARG_WIDTH'(-int'(LIMIT << ARG_FRAC));

  logic [ACT_WIDTH-1:0] lut [LutSize];

  for (genvar i = 0; i < LutSize; i++) begin : g_lut
    assign lut[i] = ACT_WIDTH'(lut_entry(i, LUT_BITS, ARG_FRAC, ACT_WIDTH));
  end

  // Forward path
  logic signed [ARG_WIDTH-1:0] arg;
  logic [ACT_WIDTH-1:0]        y_lookup;
  logic                        arg_ready, arg_fire;
  logic                        act_valid_q;
  logic [ACT_WIDTH-1:0]        act_data_q;
  logic [CntW-1:0]             pending_cnt;

  assign arg = signed'(bus.argument_data);

  always_comb begin
    y_lookup = lut[bus.argument_data[LUT_BITS-1:0]];
    if (arg >= ArgHi) begin
      y_lookup = '1;
    end else if (arg < ArgLo) begin
      y_lookup = '0;
    end
  end

  assign arg_ready = (!act_valid_q || bus.activation_ready) &&
                     (!train || pending_cnt < CntW'(DEPTH));
  assign arg_fire  = bus.argument_valid && arg_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      act_valid_q <= 1'b0;
    end else if (arg_fire) begin
      act_valid_q <= 1'b1;
    end else if (bus.activation_ready) begin
      act_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (arg_fire) act_data_q <= y_lookup;
  end

  // Backward path
  logic                     fb_ready, fb_fire;
  logic [ACT_WIDTH-1:0]     y_head;
  logic [YW-1:0]            y_ext, y_comp, y_prod;
  logic [ACT_WIDTH:0]       deriv;
  logic signed [ProdW-1:0]  fb_ext, d_ext, prod, prod_adj;
  logic [ARG_WIDTH-1:0]     delta_next;
  logic                     delta_valid_q;
  logic [ARG_WIDTH-1:0]     delta_data_q;
  logic                     unused_prod_bits;

  activation_fifo #(
    .DEPTH    (DEPTH),
    .ACT_WIDTH(ACT_WIDTH)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .push     (arg_fire && train),
    .push_data(y_lookup),
    .pop      (fb_fire),
    .head     (y_head),
    .count    (pending_cnt)
  );

  assign fb_ready = (pending_cnt != '0) && (!delta_valid_q || bus.delta_ready);
  assign fb_fire  = bus.feedback_valid && fb_ready;

  assign y_ext  = {{(ACT_WIDTH + 1){1'b0}}, y_head};
  assign y_comp = (YW'(1) << ACT_WIDTH) - y_ext;
  assign y_prod = y_ext * y_comp;
  assign deriv  = y_prod[ACT_WIDTH +: ACT_WIDTH + 1];

  assign fb_ext = {{(ACT_WIDTH + 2){bus.feedback_data[ARG_WIDTH-1]}}, bus.feedback_data};
  assign d_ext  = {{(ARG_WIDTH + 1){1'b0}}, deriv};
  assign prod   = fb_ext * d_ext;

`ifdef ACTIVATION_UNIT_ROUND_EN
  localparam logic signed [ProdW-1:0] RoundBias = ProdW'(1) << (ACT_WIDTH - 1);
  assign prod_adj = prod + RoundBias;
`else
  assign prod_adj = prod;
`endif

  // Slicing above the fraction is the arithmetic shift followed by truncation.
  assign delta_next       = prod_adj[ACT_WIDTH +: ARG_WIDTH];
  assign unused_prod_bits = ^{y_prod[ACT_WIDTH-1:0], prod_adj[ACT_WIDTH-1:0],
                              prod_adj[ProdW-1 -: 2]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      delta_valid_q <= 1'b0;
    end else if (fb_fire) begin
      delta_valid_q <= 1'b1;
    end else if (bus.delta_ready) begin
      delta_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (fb_fire) delta_data_q <= delta_next;
  end

  assign bus.argument_ready   = arg_ready;
  assign bus.activation_valid = act_valid_q;
  assign bus.activation_data  = act_data_q;
  assign bus.feedback_ready   = fb_ready;
  assign bus.delta_valid      = delta_valid_q;
  assign bus.delta_data       = delta_data_q;
  assign pending              = pending_cnt;

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit: lookup values, delta math, store occupancy,
// stall stability, reset behaviour and a random-stall forward stream.
module tb_activation_unit;
  import activation_pkg::*;

  localparam int Timeout = 50;

  logic       clock = 1'b0;
  logic       reset;
  logic       train;
  logic [2:0] pending;
  int         checks   = 0;
  int         failures = 0;
  int         waited;

  activation_if #(.ARG_WIDTH(16), .ACT_WIDTH(8)) bus ();

  activation_unit dut (
    .clock  (clock),
    .reset  (reset),
    .train  (train),
    .bus    (bus),
    .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered and left at posedge+1; ready is sampled on the falling edge.
  task automatic send_arg(input logic [15:0] a, output int w);
    w = 0;
    bus.argument_valid = 1'b1;
    bus.argument_data  = a;
    @(negedge clock);
    while (!bus.argument_ready && w < Timeout) begin
      @(negedge clock);
      w++;
    end
    check("arg_handshake", 32'(w < Timeout), 32'd1);
    @(posedge clock);
    #1;
    bus.argument_valid = 1'b0;
  endtask

  task automatic send_fb(input logic [15:0] f, output int w);
    w = 0;
    bus.feedback_valid = 1'b1;
    bus.feedback_data  = f;
    @(negedge clock);
    while (!bus.feedback_ready && w < Timeout) begin
      @(negedge clock);
      w++;
    end
    check("fb_handshake", 32'(w < Timeout), 32'd1);
    @(posedge clock);
    #1;
    bus.feedback_valid = 1'b0;
  endtask

  logic [15:0] vec_arg [5] = '{16'h0000, 16'h0600, 16'h8000, 16'hFA00, 16'h0100};
  logic [7:0]  vec_exp [5] = '{8'd128, 8'd255, 8'd0, 8'd0, 8'd187};

  initial begin
    reset = 1'b0;
    train = 1'b0;
    bus.argument_valid   = 1'b0;
    bus.argument_data    = '0;
    bus.activation_ready = 1'b0;
    bus.feedback_valid   = 1'b0;
    bus.feedback_data    = '0;
    bus.delta_ready      = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_act_valid", 32'(bus.activation_valid), 32'd0);
    check("rst_delta_valid", 32'(bus.delta_valid), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_fb_ready", 32'(bus.feedback_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rst_arg_ready", 32'(bus.argument_ready), 32'd1);

    // Lookup values, train low
    bus.activation_ready = 1'b1;
    bus.delta_ready      = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_arg(vec_arg[i], waited);
      #1;
      check("lut_valid", 32'(bus.activation_valid), 32'd1);
      check("lut_data", 32'(bus.activation_data), 32'(vec_exp[i]));
    end
    check("lut_no_store", 32'(pending), 32'd0);
    @(posedge clock);
    #1;
    check("act_drain", 32'(bus.activation_valid), 32'd0);

    // Activation stall holds data
    bus.activation_ready = 1'b0;
    send_arg(16'h0100, waited);
    repeat (5) begin
      #1;
      check("stall_valid", 32'(bus.activation_valid), 32'd1);
      check("stall_data", 32'(bus.activation_data), 32'd187);
      check("stall_arg_ready", 32'(bus.argument_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    bus.activation_ready = 1'b1;
    @(posedge clock);
    #1;
    check("stall_release", 32'(bus.activation_valid), 32'd0);

    // Basic training round trip
    train = 1'b1;
    send_arg(16'h0000, waited);
    #1;
    check("train_pending1", 32'(pending), 32'd1);
    send_fb(16'h0100, waited);
    #1;
    check("delta_valid", 32'(bus.delta_valid), 32'd1);
    check("delta_y128", 32'(bus.delta_data), 32'h0040);
    check("train_pending0", 32'(pending), 32'd0);
    check("fb_ready_empty", 32'(bus.feedback_ready), 32'd0);

    // Negative feedback rounding, then in-order pops
    send_arg(16'h0000, waited);
    send_fb(16'hFFFF, waited);
    #1;
`ifdef ACTIVATION_UNIT_ROUND_EN
    check("delta_neg_small", 32'(bus.delta_data), 32'h0000);
`else
    check("delta_neg_small", 32'(bus.delta_data), 32'hFFFF);
`endif
    send_arg(16'h0100, waited);
    send_arg(16'hFF00, waited);
    #1;
    check("order_pending2", 32'(pending), 32'd2);
    send_fb(16'h0200, waited);
    #1;
    check("delta_y187", 32'(bus.delta_data), 32'h0064);
    send_fb(16'hFD00, waited);
    #1;
    check("delta_y68_neg", 32'(bus.delta_data), 32'hFF6D);
    check("order_pending0", 32'(pending), 32'd0);

    // Full store blocks arguments, not feedback
    send_arg(16'h0000, waited);
    send_arg(16'h0100, waited);
    send_arg(16'hFF00, waited);
    send_arg(16'h0600, waited);
    #1;
    check("full_pending", 32'(pending), 32'd4);
    check("full_arg_ready", 32'(bus.argument_ready), 32'd0);
    check("full_fb_ready", 32'(bus.feedback_ready), 32'd1);
    send_fb(16'h0100, waited);
    #1;
    check("full_pop_delta", 32'(bus.delta_data), 32'h0040);
    check("full_pop_arg_ready", 32'(bus.argument_ready), 32'd1);
    check("full_pop_pending", 32'(pending), 32'd3);

    // Simultaneous push and pop
    bus.argument_valid = 1'b1;
    bus.argument_data  = 16'h0000;
    bus.feedback_valid = 1'b1;
    bus.feedback_data  = 16'h0100;
    @(negedge clock);
    check("both_arg_ready", 32'(bus.argument_ready), 32'd1);
    check("both_fb_ready", 32'(bus.feedback_ready), 32'd1);
    @(posedge clock);
    #1;
    bus.argument_valid = 1'b0;
    bus.feedback_valid = 1'b0;
    #1;
    check("both_pending", 32'(pending), 32'd3);
    check("both_delta", 32'(bus.delta_data), 32'h0032);
    check("both_act", 32'(bus.activation_data), 32'd128);

    // Build pending=3 with both outputs stalled, then reset
    send_fb(16'h0100, waited);
    bus.delta_ready = 1'b0;
    #1;
    check("pre_rst_delta", 32'(bus.delta_data), 32'h0031);
    check("pre_rst_pending2", 32'(pending), 32'd2);
    bus.activation_ready = 1'b0;
    send_arg(16'h0600, waited);
    repeat (5) begin
      #1;
      check("hold_act_valid", 32'(bus.activation_valid), 32'd1);
      check("hold_act_data", 32'(bus.activation_data), 32'd255);
      check("hold_delta_valid", 32'(bus.delta_valid), 32'd1);
      check("hold_delta_data", 32'(bus.delta_data), 32'h0031);
      check("hold_pending", 32'(pending), 32'd3);
      check("hold_fb_ready", 32'(bus.feedback_ready), 32'd0);
      @(posedge clock);
      #1;
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("rst2_act_valid", 32'(bus.activation_valid), 32'd0);
    check("rst2_delta_valid", 32'(bus.delta_valid), 32'd0);
    check("rst2_pending", 32'(pending), 32'd0);
    check("rst2_fb_ready", 32'(bus.feedback_ready), 32'd0);
    reset = 1'b1;
    #1;
    check("rst2_arg_ready", 32'(bus.argument_ready), 32'd1);
    bus.activation_ready = 1'b1;
    bus.delta_ready      = 1'b1;
    send_arg(16'hFF00, waited);
    check("rst2_first_accept", 32'(waited), 32'd0);
    #1;
    check("rst2_act_data", 32'(bus.activation_data), 32'd68);
    check("rst2_pending1", 32'(pending), 32'd1);

    // Train deasserted: stored entries still drain, new results not stored
    send_arg(16'h0000, waited);
    train = 1'b0;
    send_arg(16'h0100, waited);
    #1;
    check("notrain_pending", 32'(pending), 32'd2);
    check("notrain_act", 32'(bus.activation_data), 32'd187);
    send_fb(16'h0100, waited);
    #1;
    check("drain_delta1", 32'(bus.delta_data), 32'h0031);
    send_fb(16'h0100, waited);
    #1;
    check("drain_delta2", 32'(bus.delta_data), 32'h0040);
    check("drain_pending", 32'(pending), 32'd0);

    // Random stalls on the forward stream
    @(posedge clock);
    #1;
    fork
      begin
        int w;
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clock);
            #1;
          end
          send_arg(vec_arg[i % 5], w);
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < 100 && cyc < 3000) begin
          @(negedge clock);
          if (bus.activation_valid && bus.activation_ready) begin
            check("rand_data", 32'(bus.activation_data), 32'(vec_exp[got % 5]));
            got++;
          end
          cyc++;
          @(posedge clock);
          #1;
          bus.activation_ready = 1'($urandom_range(0, 1));
        end
        check("rand_count", 32'(got), 32'd100);
      end
    join
    check("rand_no_extra", 32'(bus.activation_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
